// File: rtl/mure_uop_buffer.sv
// Multi-lane commit-to-encoder uop buffer: classifies up to NRET retired instructions per
// cycle and queues them in a circular buffer. Optional MURE_DROP_CNT_EN adds drop_cnt_o.
module mure_uop_buffer #(
  parameter int unsigned NRET      = 2,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned ITYPE_LEN = 3,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned PRIV_LEN  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic [NRET-1:0]         valid_i,
  input  logic [NRET*32-1:0]      inst_i,
  input  logic [NRET*XLEN-1:0]    iaddr_i,
  input  logic [NRET-1:0]         taken_i,
  input  logic [NRET-1:0]         exc_i,
  input  logic [NRET-1:0]         int_i,
  input  logic [PRIV_LEN-1:0]     priv_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [ITYPE_LEN-1:0]    itype_o,
  output logic [XLEN-1:0]         iaddr_o,
  output logic [1:0]              ilastsize_o,
  output logic [PRIV_LEN-1:0]     priv_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    overflow_o
`ifdef MURE_DROP_CNT_EN
  ,
  output logic [15:0]             drop_cnt_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [3:0] {
    IT_STD  = 4'd0,
    IT_EXC  = 4'd1,
    IT_INT  = 4'd2,
    IT_ERET = 4'd3,
    IT_NTB  = 4'd4,
    IT_TB   = 4'd5,
    IT_UJ   = 4'd6,
    IT_UC   = 4'd8,
    IT_IC   = 4'd9,
    IT_RET  = 4'd13,
    IT_OUJ  = 4'd14,
    IT_OIJ  = 4'd15
  } itype_e;

  function automatic logic [ITYPE_LEN-1:0] classify(input logic [31:0] w, input logic tk,
                                                    input logic ex, input logic irq);
    itype_e     code;
    logic [4:0] rd, rs1;
    logic       rvc, br, jal, jalr, cj, cjr, cjalr;
    rd    = w[11:7];
    rs1   = w[19:15];
    rvc   = w[1:0] != 2'b11;
    // 32-bit branch opcode also covers the PULP p.beqimm/p.bneimm funct3 slots
    br    = (!rvc && w[6:0] == 7'b1100011) || (w[1:0] == 2'b01 && w[15:14] == 2'b11);
    jal   = !rvc && w[6:0] == 7'b1101111;
    jalr  = !rvc && w[6:0] == 7'b1100111 && w[14:12] == 3'b000;
    cj    = w[1:0] == 2'b01 && w[15:13] == 3'b101;
    cjr   = w[1:0] == 2'b10 && w[15:12] == 4'b1000 && rd != '0 && w[6:2] == '0;
    cjalr = w[1:0] == 2'b10 && w[15:12] == 4'b1001 && rd != '0 && w[6:2] == '0;
    code  = IT_STD;
    if (ex)
      code = IT_EXC;
    else if (irq)
      code = IT_INT;
    else if (w == 32'h30200073 || w == 32'h10200073 || w == 32'h00200073)
      code = IT_ERET;
    else if (br)
      code = tk ? IT_TB : IT_NTB;
    else if (ITYPE_LEN == 3) begin
      if (jalr || cjr || cjalr)
        code = IT_UJ;
    end else begin
      if ((jalr && rd == 5'd1) || cjalr)
        code = IT_UC;
      else if (jal && rd == 5'd1)
        code = IT_IC;
      else if ((jalr && rd == 5'd0 && rs1 == 5'd1) || (cjr && rd == 5'd1))
        code = IT_RET;
      else if (jalr || cjr)
        code = IT_OUJ;
      else if (jal || cj)
        code = IT_OIJ;
    end
    return ITYPE_LEN'(code);
  endfunction

  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [CW-1:0]        lanes;
  logic [AW-1:0]        slot [NRET];
  logic [ITYPE_LEN-1:0] lane_it [NRET];
  logic                 lane_sz [NRET];
  logic                 fits, push, drop, pop;

  logic [ITYPE_LEN-1:0] mem_it   [DEPTH];
  logic [XLEN-1:0]      mem_addr [DEPTH];
  logic                 mem_sz   [DEPTH];
  logic [PRIV_LEN-1:0]  mem_priv [DEPTH];

  // Valid lanes are compacted: each takes the slot after all lower valid lanes
  always_comb begin
    lanes = '0;
    for (int unsigned i = 0; i < NRET; i++) begin
      slot[i]    = wr_ptr + AW'(lanes);
      lane_it[i] = classify(inst_i[i*32 +: 32], taken_i[i], exc_i[i], int_i[i]);
      lane_sz[i] = inst_i[i*32 +: 2] == 2'b11;
      if (valid_i[i])
        lanes = lanes + CW'(1);
    end
  end

  always_comb begin
    fits = lanes <= (CW'(DEPTH) - count);
    push = !flush_i && (valid_i != '0) && fits;
    drop = !flush_i && !fits;
    pop  = !flush_i && (count != '0) && ready_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else if (flush_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(lanes);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + (push ? lanes : '0) - CW'(pop);
      if (drop)
        overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      for (int unsigned i = 0; i < NRET; i++) begin
        if (valid_i[i]) begin
          mem_it[slot[i]]   <= lane_it[i];
          mem_addr[slot[i]] <= iaddr_i[i*XLEN +: XLEN];
          mem_sz[slot[i]]   <= lane_sz[i];
          mem_priv[slot[i]] <= priv_i;
        end
      end
    end
  end

  // Head fields are forced to zero while empty so reset/flush present clean outputs
  always_comb begin
    valid_o     = count != '0;
    itype_o     = valid_o ? mem_it[rd_ptr]   : '0;
    iaddr_o     = valid_o ? mem_addr[rd_ptr] : '0;
    priv_o      = valid_o ? mem_priv[rd_ptr] : '0;
    ilastsize_o = {1'b0, valid_o & mem_sz[rd_ptr]};
    count_o     = count;
  end

`ifdef MURE_DROP_CNT_EN
  logic [16:0] drop_sum;

  always_comb drop_sum = {1'b0, drop_cnt_o} + 17'(lanes);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      drop_cnt_o <= '0;
    else if (flush_i)
      drop_cnt_o <= '0;
    else if (drop)
      drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
`endif

endmodule

// File: doc/mure_uop_buffer.md
Name: mure_uop_buffer

Overview:
- Multi-lane successor of the single-entry uop path: accepts up to NRET committed instructions per cycle from the core commit ports, classifies each into an itype (3- or 4-bit encoding), and queues them in a parametrised circular buffer.
- Drains one uop per cycle to the trace encoder over a valid/ready handshake.
- Sits between the core commit stage and the encoder; the commit stage cannot be stalled, so overflow is detected and reported, never back-pressured.

Parameters:
- NRET, 2, commit lanes per cycle (1..4)
- DEPTH, 16, buffer entries; power of two, at least 2*NRET
- ITYPE_LEN, 3, itype width; 3 = basic encoding, 4 = extended encoding
- XLEN, 32, address width (64 when TRDB_ARCH64)
- PRIV_LEN, 2, privilege width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  synchronous clear of buffer and flags
- valid_i  in  NRET  per-lane commit valid
- inst_i  in  NRET*32  per-lane instruction word
- iaddr_i  in  NRET*XLEN  per-lane instruction address
- taken_i  in  NRET  per-lane branch-taken flag
- exc_i  in  NRET  per-lane exception flag
- int_i  in  NRET  per-lane interrupt flag
- priv_i  in  PRIV_LEN  privilege level, shared by all lanes of the cycle
- valid_o  out  1  head entry valid
- ready_i  in  1  encoder accepts head
- itype_o  out  ITYPE_LEN  head itype
- iaddr_o  out  XLEN  head address
- ilastsize_o  out  2  head size: 0 = 16-bit, 1 = 32-bit
- priv_o  out  PRIV_LEN  head privilege
- count_o  out  $clog2(DEPTH)+1  occupancy
- overflow_o  out  1  sticky drop flag

Behaviour:
- Reset (async, rst_i=1): pointers=0, count_o=0, valid_o=0, overflow_o=0. All data outputs are 0.
- Classification is combinational per lane, in priority order:
  - exc_i -> EXC(1)
  - int_i -> INT(2)
  - mret/sret/uret (full-word match) -> ERET(3)
  - branch (beq/bne/blt/bge/bltu/bgeu/p.beqimm/p.bneimm/c.beqz/c.bnez) -> TB(5) if taken_i, else NTB(4)
  - jumps:
    - ITYPE_LEN=3: jalr/c.jr/c.jalr -> UJ(6); jal/c.j -> STD
    - ITYPE_LEN=4: jalr/c.jalr with rd=x1 -> UC(8); jal with rd=x1 -> IC(9); jalr rd=x0 with rs1=x1, or c.jr rs1=x1 -> RET(13); other jalr/c.jr -> OUJ(14); other jal/c.j -> OIJ(15)
  - everything else -> STD(0). CRS is never produced.
- ilastsize: 0 when inst[1:0]!=2'b11, otherwise 1.
- Push:
  - Valid lanes are compacted in ascending lane order and written at wr_ptr, wr_ptr+1, ...
  - Pointers wrap modulo DEPTH.
  - Entries are visible at the output the cycle after the write (1-cycle latency).
- All-or-nothing acceptance: a cycle's lanes are written only if popcount(valid_i) <= DEPTH - count (count before any pop in that cycle). Otherwise all lanes of that cycle are dropped and overflow_o is set (sticky).
- Pop:
  - Occurs when valid_o && ready_i; rd_ptr advances by 1.
  - valid_o = (count != 0).
  - Outputs are registered from the head entry and stable while valid_o && !ready_i.
- Simultaneous push and pop: count_next = count + pushed - popped. count_o never exceeds DEPTH.
- flush_i:
  - Next edge: pointers=0, count=0, overflow_o=0.
  - Has priority over push and pop in the same cycle; lanes presented with flush are discarded and do not set overflow.
- Empty with ready_i=1: no pop, pointers unchanged.
- Reset mid-operation: all state is cleared immediately; in-flight lanes are lost.

Optional Feature:
- Macro: MURE_DROP_CNT_EN.
- When defined: adds output drop_cnt_o (16 bits), a saturating count of dropped lanes; it adds popcount(valid_i) per overflowing cycle and holds at 16'hFFFF. Cleared by rst_i and flush_i.
- When undefined: port and counter are absent; only overflow_o reports drops.

Test Plan:
- NRET=2, ITYPE_LEN=3: lane0 beq 32'h00000063 with taken=1, lane1 jalr 32'h000080E7 -> next two pops give itype 5 then 6, both with ilastsize 1.
- ITYPE_LEN=4:
  - 32'h000080E7 (jalr ra) -> UC(8)
  - 32'h00008067 (ret) -> RET(13)
  - 16'h8082 (c.jr ra) -> RET(13), ilastsize 0
  - 32'h008000EF (jal ra) -> IC(9)
- Lane ordering and wrap: valid_i=2'b10, then 2'b11 with ready_i=0 -> count_o=3; the first pop returns the lane1 address of cycle 1. Pushing past DEPTH with pops keeps wrap order correct.
- Overflow: DEPTH=4, ready_i=0, fill to 3, then valid_i=2'b11 -> both lanes dropped, count_o stays 3, overflow_o=1; with MURE_DROP_CNT_EN, drop_cnt_o=2.
- Simultaneous push of 2 and pop at count 1 -> count_o=2 next cycle; flush_i asserted together with valid_i=2'b11 -> count_o=0, overflow_o=0, valid_o=0.
- Assert rst_i asynchronously mid-burst -> valid_o and count_o drop to 0 before the next clock edge.
